disp_scheduler: RTL
===================

# disp_scheduler

Display source scheduler for the alarm clock's six-digit seven-segment display. It chooses which 24-bit BCD word (current time, alarm setpoint, or a transient alarm "peek") drives the display driver's `num` input, using a fixed priority state machine. It also generates the blink mask for the field being edited and the full-display flash while the alarm rings. It sits between the timekeeping/alarm registers and the display driver; the driver forces a digit dark when its `blank` bit is 1.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; the 1 ms tick divisor is `CLK_HZ/1000`.
- `BLINK_HALF_MS`, 250, length of each blink half-period, in ms ticks.
- `HOLD_MS`, 3000, how long a peek shows the alarm setpoint, in ms ticks.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `time_bcd`  in  24  current time HH:MM:SS, BCD; [23:20] is the leftmost digit
- `alarm_bcd`  in  24  alarm setpoint HH:MM:SS, BCD
- `set_mode`  in  2  0 none, 1 edit time, 2 edit alarm, 3 treated as 0
- `set_field`  in  2  0 HH, 1 MM, 2 SS, 3 no field
- `peek_req`  in  1  single-cycle pulse requesting an alarm-setpoint peek
- `ring`  in  1  level; high while the alarm is sounding
- `num`  out  24  BCD word to the display driver
- `blank`  out  6  per-digit blank; bit i corresponds to `num[4i+3:4i]`
- `src`  out  2  0 time, 1 alarm setpoint, 2 ring
- `peek_active`  out  1  high while in state PEEK

## Operation
States: TIME, EDIT_T, EDIT_A, PEEK, RING. Priority: RING > EDIT > PEEK > TIME.

Next-state rules, evaluated every cycle:
- `ring` high → RING.
- Else `set_mode`=1 → EDIT_T; `set_mode`=2 → EDIT_A.
- Else, if `peek_req` is high, or the state is PEEK and the peek timer has not expired → PEEK.
- Else → TIME.

Peek timer:
- Cleared on entry to PEEK and on every `peek_req` while in PEEK (retrigger).
- Advances on each ms tick. Expires when the count reaches `HOLD_MS`-1 on a tick; the state becomes TIME next cycle.
- Cleared whenever the state leaves PEEK, so the peek does not resume after RING or EDIT ends.

Timing counters:
- The ms prescaler runs freely from 0 to `CLK_HZ/1000`-1 and pulses `tick` at the wrap.
- The blink counter counts ticks from 0 to `BLINK_HALF_MS`-1, then toggles `phase`.
- The blink counter and `phase` are cleared to 0 (visible) on any state change or `set_field` change, so edits show immediately.

Output selection:
- TIME: `num`=`time_bcd`, `src`=0, `blank`=0.
- EDIT_T: `num`=`time_bcd`, `src`=0.
- EDIT_A and PEEK: `num`=`alarm_bcd`, `src`=1.
- RING: `num`=`time_bcd`, `src`=2, `blank`=6'b111111 when `phase`=1, else 0.
- Edit blanking when `phase`=1: HH → 6'b110000, MM → 6'b001100, SS → 6'b000011, field 3 → 0. When `phase`=0, `blank`=0.
- PEEK: `blank`=0.

Width rules: `num` is passed through unmodified; no BCD validation. Counters are sized with `$clog2` of their terminal value.

## Timing
- All outputs are registered. Any input change affects `num`/`blank`/`src` exactly one clock later (one cycle for the state register, with outputs decoded from the next state).
- Reset values: `num`=0, `blank`=0, `src`=0, `peek_active`=0. State is TIME; all counters and `phase` are 0.
- Reset asserted mid-PEEK or mid-RING returns to reset values immediately; no peek or flash resumes after release.
- `peek_req` arriving while in EDIT or RING is dropped, not queued.
- `ring` rising in the same cycle as `peek_req` → RING.
- `set_mode` changing during RING has no visible effect until `ring` falls; then the rules resolve in the next cycle.

## Configuration
- `DISP_LZ_BLANK_EN` defined: in states TIME, EDIT_T and RING, if `num[23:20]`=0 then `blank[5]` is forced to 1. This is ORed with the other blank sources.
- Undefined: the leading zero is shown; the blank logic is exactly as in Operation.

## Test plan
Bench parameters: `CLK_HZ`=4000 (tick every 4 cycles), `BLINK_HALF_MS`=2, `HOLD_MS`=5.
- Reset, then `time_bcd`=24'h123456 → one cycle later `num`=24'h123456, `src`=0, `blank`=0, `peek_active`=0.
- `alarm_bcd`=24'h070000, `peek_req` pulse → `num`=24'h070000, `src`=1, `peek_active`=1 for 5 ticks (about 20 cycles), then `num`=`time_bcd`. A second pulse at tick 3 extends the peek to 8 ticks total.
- `set_mode`=2, `set_field`=1 → `blank` alternates 6'b000000 / 6'b001100 every 2 ticks, starting visible. Switching to `set_field`=2 gives an immediately visible phase, then 6'b000011.
- `ring`=1 during PEEK → RING, `src`=2, `blank` toggles 0 / 6'b111111 every 2 ticks. `ring`=0 → TIME (the peek does not resume).
- `ring` and `peek_req` asserted in the same cycle → RING. Assert `rst_n`=0 mid-flash → all outputs 0 asynchronously.
- With `DISP_LZ_BLANK_EN` defined, `time_bcd`=24'h093000 → `blank`=6'b100000. With the macro undefined → `blank`=0.

Source files
------------

// File: rtl/disp_scheduler.sv
// disp_scheduler: picks the time / alarm / peek word for the six-digit display and builds
// the edit blink and ring flash masks. Optional macro DISP_LZ_BLANK_EN blanks a leading-zero hour digit.
module disp_scheduler #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BLINK_HALF_MS = 250,
    parameter int HOLD_MS       = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] time_bcd,
    input  logic [23:0] alarm_bcd,
    input  logic [1:0]  set_mode,
    input  logic [1:0]  set_field,
    input  logic        peek_req,
    input  logic        ring,
    output logic [23:0] num,
    output logic [5:0]  blank,
    output logic [1:0]  src,
    output logic        peek_active
);
    localparam int DIV    = CLK_HZ / 1000;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLK_W  = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
    localparam int HOLD_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_HALF_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);

    typedef enum logic [2:0] {S_TIME, S_EDIT_T, S_EDIT_A, S_PEEK, S_RING} state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [BLK_W-1:0]    blink_q, blink_d;
    logic                phase_q, phase_d;
    logic [HOLD_W-1:0]   peek_cnt_q, peek_cnt_d;
    logic [1:0]          field_q, field_d;
    logic [23:0]         num_q, num_d;
    logic [5:0]          blank_q, blank_d;
    logic [1:0]          src_q, src_d;
    logic                peek_active_q, peek_active_d;
    logic                tick, peek_done;

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
        peek_done = (state_q == S_PEEK) && tick && (peek_cnt_q == HOLD_LAST);

        if (ring)                                              state_d = S_RING;
        else if (set_mode == 2'd1)                             state_d = S_EDIT_T;
        else if (set_mode == 2'd2)                             state_d = S_EDIT_A;
        else if (peek_req || (state_q == S_PEEK && !peek_done)) state_d = S_PEEK;
        else                                                   state_d = S_TIME;

        // Any exit from PEEK forgets the timer, so a peek never resumes after RING/EDIT.
        if (state_d != S_PEEK || state_q != S_PEEK || peek_req) peek_cnt_d = '0;
        else if (tick)                                          peek_cnt_d = peek_cnt_q + 1'b1;
        else                                                    peek_cnt_d = peek_cnt_q;

        field_d = set_field;
        blink_d = blink_q;
        phase_d = phase_q;
        if (state_d != state_q || set_field != field_q) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (blink_q == BLK_LAST) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end

        num_d         = (state_d == S_EDIT_A || state_d == S_PEEK) ? alarm_bcd : time_bcd;
        peek_active_d = (state_d == S_PEEK);
        case (state_d)
            S_RING:           src_d = 2'd2;
            S_EDIT_A, S_PEEK: src_d = 2'd1;
            default:          src_d = 2'd0;
        endcase

        blank_d = '0;
        if (phase_d) begin
            case (state_d)
                S_RING: blank_d = 6'b111111;
                S_EDIT_T, S_EDIT_A: begin
                    case (set_field)
                        2'd0:    blank_d = 6'b110000;
                        2'd1:    blank_d = 6'b001100;
                        2'd2:    blank_d = 6'b000011;
                        default: blank_d = 6'b000000;
                    endcase
                end
                default: blank_d = '0;
            endcase
        end
`ifdef DISP_LZ_BLANK_EN
        if ((state_d == S_TIME || state_d == S_EDIT_T || state_d == S_RING) && num_d[23:20] == 4'd0)
            blank_d[5] = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_TIME;
            pre_q         <= '0;
            blink_q       <= '0;
            phase_q       <= 1'b0;
            peek_cnt_q    <= '0;
            field_q       <= '0;
            num_q         <= '0;
            blank_q       <= '0;
            src_q         <= '0;
            peek_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            blink_q       <= blink_d;
            phase_q       <= phase_d;
            peek_cnt_q    <= peek_cnt_d;
            field_q       <= field_d;
            num_q         <= num_d;
            blank_q       <= blank_d;
            src_q         <= src_d;
            peek_active_q <= peek_active_d;
        end
    end

    assign num         = num_q;
    assign blank       = blank_q;
    assign src         = src_q;
    assign peek_active = peek_active_q;
endmodule
